// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: runs one SD command transaction (isr clear, cmd/arg write, isr poll, response read) over the 8-bit register port.
// Offsets follow sd_defines.h; define SD_SEQ_WDOG_EN to add the poll watchdog.
module sd_cmd_sequencer #(
    parameter int                POLL_GAP   = 16,
    parameter int                WDOG_W     = 20,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 20'hFFFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [15:0]  req_cmd,
    input  logic [31:0]  req_arg,
    input  logic         req_long,
    output logic         done,
    output logic [7:0]   status,
    output logic [127:0] resp,
    output logic         bus_we,
    output logic [6:0]   bus_addr,
    output logic [7:0]   bus_wdata,
    input  logic [7:0]   bus_rdata
);
    localparam logic [6:0] A_ARG   = 7'h00;
    localparam logic [6:0] A_CMD   = 7'h04;
    localparam logic [6:0] A_RESP0 = 7'h08;
    localparam logic [6:0] A_ISR   = 7'h34;

    localparam int CW = $clog2((POLL_GAP > 16 ? POLL_GAP : 16) + 1);
    localparam logic [CW-1:0] GAP_END = CW'(POLL_GAP - 1);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_CLR0 = 4'd1;
    localparam logic [3:0] S_GAP0 = 4'd2;
    localparam logic [3:0] S_WCMD = 4'd3;
    localparam logic [3:0] S_WARG = 4'd4;
    localparam logic [3:0] S_GAP  = 4'd5;
    localparam logic [3:0] S_POLL = 4'd6;
    localparam logic [3:0] S_RESP = 4'd7;
    localparam logic [3:0] S_CLR1 = 4'd8;
    localparam logic [3:0] S_GAP1 = 4'd9;
    localparam logic [3:0] S_DONE = 4'd10;

    logic [3:0]    r_state, w_nstate;
    logic [CW-1:0] r_cnt, w_ncnt;
    logic [15:0]   r_cmd;
    logic [31:0]   r_arg;
    logic          r_long;
    logic [7:0]    r_isr;
    logic          r_ready, r_done, r_we;
    logic [6:0]    r_addr, w_addr;
    logic [7:0]    r_wdata, w_wdata, r_status;
    logic [127:0]  r_resp;
    logic          w_we, w_accept, w_gap_end, w_cmp, w_err, w_fin, w_wdog;
    logic [1:0]    w_sel;

    assign w_accept  = (r_state == S_IDLE) && req_valid;
    assign w_gap_end = r_cnt == GAP_END;
    assign w_cmp     = bus_rdata[0];
    assign w_err     = bus_rdata[1];
    assign w_fin     = w_cmp || w_err;

`ifdef SD_SEQ_WDOG_EN
    logic [WDOG_W-1:0] r_polls;
    assign w_wdog = r_polls == WDOG_LIMIT - WDOG_W'(1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_polls <= '0;
        else if (w_accept)
            r_polls <= '0;
        else if (r_state == S_POLL && !w_fin)
            r_polls <= r_polls + WDOG_W'(1);
    end
`else
    assign w_wdog = 1'b0;
`endif

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt + CW'(1);
        case (r_state)
            S_IDLE: begin
                w_ncnt   = '0;
                w_nstate = req_valid ? S_CLR0 : S_IDLE;
            end
            S_CLR0: begin
                w_ncnt   = '0;
                w_nstate = S_GAP0;
            end
            S_GAP0: if (w_gap_end) begin
                w_ncnt   = '0;
                w_nstate = S_WCMD;
            end
            S_WCMD: if (r_cnt[0]) begin
                w_ncnt   = '0;
                w_nstate = S_WARG;
            end
            S_WARG: if (r_cnt == CW'(3)) begin
                w_ncnt   = '0;
                w_nstate = S_GAP;
            end
            S_GAP: if (w_gap_end) begin
                w_ncnt   = '0;
                w_nstate = S_POLL;
            end
            S_POLL: begin
                w_ncnt   = '0;
                w_nstate = (w_fin || w_wdog) ? ((w_cmp && !w_err) ? S_RESP : S_CLR1) : S_GAP;
            end
            S_RESP: if (r_cnt == (r_long ? CW'(15) : CW'(3))) begin
                w_ncnt   = '0;
                w_nstate = S_CLR1;
            end
            S_CLR1: begin
                w_ncnt   = '0;
                w_nstate = S_GAP1;
            end
            S_GAP1: if (w_gap_end) begin
                w_ncnt   = '0;
                w_nstate = S_DONE;
            end
            default: begin
                w_ncnt   = '0;
                w_nstate = S_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from the next state so they are registered exactly in the cycle of the operation.
    always_comb begin
        w_sel   = ~w_ncnt[1:0];
        w_we    = (w_nstate == S_CLR0) || (w_nstate == S_CLR1) || (w_nstate == S_WCMD) || (w_nstate == S_WARG);
        w_addr  = r_addr;
        w_wdata = r_wdata;
        case (w_nstate)
            S_CLR0, S_CLR1: begin
                w_addr  = A_ISR;
                w_wdata = 8'h00;
            end
            S_POLL: w_addr = A_ISR;
            S_WCMD: begin
                w_addr  = {A_CMD[6:2], 1'b0, ~w_ncnt[0]};
                w_wdata = w_ncnt[0] ? r_cmd[7:0] : r_cmd[15:8];
            end
            S_WARG: begin
                w_addr  = {A_ARG[6:2], w_sel};
                w_wdata = r_arg[{w_sel, 3'b000} +: 8];
            end
            S_RESP: w_addr = {A_RESP0[6:2] + {3'b000, w_ncnt[3:2]}, w_ncnt[1:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_cmd    <= '0;
            r_arg    <= '0;
            r_long   <= 1'b0;
            r_isr    <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_status <= '0;
            r_resp   <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_ready <= w_nstate == S_IDLE;
            r_done  <= w_nstate == S_DONE;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            if (w_accept) begin
                r_cmd    <= req_cmd;
                r_arg    <= req_arg;
                r_long   <= req_long;
                r_resp   <= '0;
                r_status <= '0;
            end
            if (r_state == S_POLL)
                r_isr <= (bus_rdata & 8'h7f) | {w_wdog && !w_fin, 7'b0};
            if (r_state == S_RESP)
                r_resp[{r_cnt[3:0], 3'b000} +: 8] <= bus_rdata;
            if (w_nstate == S_DONE)
                r_status <= r_isr;
        end
    end

    assign req_ready = r_ready;
    assign done      = r_done;
    assign status    = r_status;
    assign resp      = r_resp;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
endmodule
